// File: rtl/psel_req_issuer.sv
// Requester-side slot table for the rotating priority selector: drives req, retires granted slots,
// ages waiting slots. Optional sticky illegal-grant flags under `PSEL_REQ_ISSUER_DEBUG_EN.
module psel_req_issuer #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned TAG_W = 6,
   parameter int unsigned AGE_W = 4
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic [WIDTH-1:0]         i_load_en,
   input  logic [WIDTH*TAG_W-1:0]   i_load_tag,
   input  logic [WIDTH-1:0]         i_gnt,
   output logic [WIDTH-1:0]         o_req,
   output logic [WIDTH-1:0]         o_load_stall,
   output logic                     o_issue_valid,
   output logic [$clog2(WIDTH)-1:0] o_issue_idx,
   output logic [TAG_W-1:0]         o_issue_tag,
   output logic [WIDTH-1:0]         o_starve,
`ifdef PSEL_REQ_ISSUER_DEBUG_EN
   output logic                     o_err_gnt_empty,
   output logic                     o_err_gnt_multi,
`endif
   output logic [$clog2(WIDTH):0]   o_n_pending
);

   localparam int unsigned IDX_W = $clog2(WIDTH);
   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   typedef enum logic {StEmpty, StPending} slot_st_e;

   slot_st_e         r_st      [WIDTH];
   slot_st_e         w_st_nxt  [WIDTH];
   logic [TAG_W-1:0] r_tag     [WIDTH];
   logic [TAG_W-1:0] w_tag_nxt [WIDTH];
   logic [AGE_W-1:0] r_age     [WIDTH];
   logic [AGE_W-1:0] w_age_nxt [WIDTH];

   logic [WIDTH-1:0] w_pend;
   logic [WIDTH-1:0] w_ret;
   logic             w_any_ret;
   logic [IDX_W-1:0] w_ret_idx;
   logic [IDX_W:0]   w_npend_nxt;

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         w_pend[i]   = (r_st[i] == StPending);
         o_starve[i] = w_pend[i] && (r_age[i] == AGE_MAX);
      end
   end

   assign o_req = w_pend;

   // Only the lowest-index granted pending slot retires; extra grant bits are treated as absent.
   always_comb begin
      w_ret     = '0;
      w_any_ret = 1'b0;
      w_ret_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!w_any_ret && w_pend[i] && i_gnt[i]) begin
            w_ret[i]  = 1'b1;
            w_any_ret = 1'b1;
            w_ret_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      o_load_stall = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_st_nxt[i]  = r_st[i];
         w_tag_nxt[i] = r_tag[i];
         w_age_nxt[i] = r_age[i];
         case (r_st[i])
            StEmpty: begin
               if (i_load_en[i]) begin
                  w_st_nxt[i]  = StPending;
                  w_tag_nxt[i] = i_load_tag[i*TAG_W +: TAG_W];
                  w_age_nxt[i] = '0;
               end
            end
            StPending: begin
               if (w_ret[i]) begin
                  if (i_load_en[i]) begin
                     w_tag_nxt[i] = i_load_tag[i*TAG_W +: TAG_W];
                     w_age_nxt[i] = '0;
                  end else begin
                     w_st_nxt[i] = StEmpty;
                  end
               end else begin
                  o_load_stall[i] = i_load_en[i];
                  if (r_age[i] != AGE_MAX) w_age_nxt[i] = r_age[i] + 1'b1;
               end
            end
            default: w_st_nxt[i] = StEmpty;
         endcase
      end
   end

   always_comb begin
      w_npend_nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_npend_nxt = w_npend_nxt + {{IDX_W{1'b0}}, (w_st_nxt[i] == StPending)};
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < WIDTH; i++) begin
            r_st[i]  <= StEmpty;
            r_tag[i] <= '0;
            r_age[i] <= '0;
         end
         o_issue_valid <= 1'b0;
         o_issue_idx   <= '0;
         o_issue_tag   <= '0;
         o_n_pending   <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            r_st[i]  <= w_st_nxt[i];
            r_tag[i] <= w_tag_nxt[i];
            r_age[i] <= w_age_nxt[i];
         end
         o_issue_valid <= w_any_ret;
         if (w_any_ret) begin
            o_issue_idx <= w_ret_idx;
            o_issue_tag <= r_tag[w_ret_idx];
         end
         o_n_pending <= w_npend_nxt;
      end
   end

`ifdef PSEL_REQ_ISSUER_DEBUG_EN
   logic w_gnt_empty;
   logic w_gnt_multi;

   assign w_gnt_empty = |(i_gnt & ~w_pend);
   assign w_gnt_multi = |(i_gnt & (i_gnt - WIDTH'(1)));

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_err_gnt_empty <= 1'b0;
         o_err_gnt_multi <= 1'b0;
      end else begin
         if (w_gnt_empty) o_err_gnt_empty <= 1'b1;
         if (w_gnt_multi) o_err_gnt_multi <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_psel_req_issuer.sv
// Directed bench for psel_req_issuer: slot-table model checked every negedge plus literal pins.
module tb_psel_req_issuer;
   localparam int W  = 16;
   localparam int TW = 6;
   localparam int IW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [W-1:0]    en = '0;
   logic [W*TW-1:0] ltag = '0;
   logic [W-1:0]    gnt = '0;
   logic [W-1:0]    req, stall, starve;
   logic            iv;
   logic [IW-1:0]   idx;
   logic [TW-1:0]   itag;
   logic [IW:0]     np;
`ifdef PSEL_REQ_ISSUER_DEBUG_EN
   logic            err_empty, err_multi;
`endif

   psel_req_issuer #(.WIDTH(W), .TAG_W(TW), .AGE_W(4)) dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_load_en      (en),
      .i_load_tag     (ltag),
      .i_gnt          (gnt),
      .o_req          (req),
      .o_load_stall   (stall),
      .o_issue_valid  (iv),
      .o_issue_idx    (idx),
      .o_issue_tag    (itag),
      .o_starve       (starve),
`ifdef PSEL_REQ_ISSUER_DEBUG_EN
      .o_err_gnt_empty(err_empty),
      .o_err_gnt_multi(err_multi),
`endif
      .o_n_pending    (np)
   );

   always #5 clk = ~clk;

   // Model: occupancy, tag and age per slot, plus the last issue record.
   bit m_pend [W];
   int m_tag  [W];
   int m_age  [W];
   bit m_iv;
   int m_idx, m_itag;
   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int find_ret(input logic [W-1:0] g);
      for (int i = 0; i < W; i++) if (g[i] && m_pend[i]) return i;
      return -1;
   endfunction

   function automatic logic [W*TW-1:0] tg(input int slot, input int t);
      logic [W*TW-1:0] v = '0;
      v[slot*TW +: TW] = TW'(t);
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < W; i++) begin
         m_pend[i] = 0; m_tag[i] = 0; m_age[i] = 0;
      end
      m_iv = 0; m_idx = 0; m_itag = 0;
   endtask

   task automatic model_step(input logic [W-1:0] e, input logic [W*TW-1:0] t,
                             input logic [W-1:0] g);
      int r = find_ret(g);
      m_iv = (r >= 0);
      if (r >= 0) begin
         m_idx = r; m_itag = m_tag[r];
      end
      for (int i = 0; i < W; i++) begin
         if (m_pend[i] && i != r) begin
            m_age[i] = (m_age[i] < 15) ? m_age[i] + 1 : 15;
         end else if (e[i]) begin
            m_pend[i] = 1; m_tag[i] = int'(t[i*TW +: TW]); m_age[i] = 0;
         end else if (i == r) begin
            m_pend[i] = 0;
         end
      end
   endtask

   always @(negedge clk) begin
      logic [W-1:0] er, es, el;
      int cnt, r;
      if (!rst) begin
         r = find_ret(gnt);
         cnt = 0;
         for (int i = 0; i < W; i++) begin
            er[i] = m_pend[i];
            es[i] = m_pend[i] && m_age[i] == 15;
            el[i] = en[i] && m_pend[i] && i != r;
            cnt += int'(m_pend[i]);
         end
         chk("req", 64'(req), 64'(er));
         chk("starve", 64'(starve), 64'(es));
         chk("load_stall", 64'(stall), 64'(el));
         chk("n_pending", 64'(np), 64'(cnt));
         chk("issue_valid", 64'(iv), 64'(m_iv));
         chk("issue_idx", 64'(idx), 64'(m_idx));
         chk("issue_tag", 64'(itag), 64'(m_itag));
      end
   end

   task automatic cyc(input logic [W-1:0] e, input logic [W*TW-1:0] t, input logic [W-1:0] g);
      en = e; ltag = t; gnt = g;
      @(posedge clk);
      #1;
      model_step(e, t, g);
      en = '0; gnt = '0; ltag = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_req_async", 64'(req), 64'h0);
      chk("rst_np_async", 64'(np), 64'h0);
      model_clear();
      en = '0; gnt = '0; ltag = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [W*TW-1:0] all_tags;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_req", 64'(req), 64'h0);
      chk("reset_iv", 64'(iv), 64'h0);
      chk("reset_itag", 64'(itag), 64'h0);
      chk("reset_np", 64'(np), 64'h0);

      cyc(16'h0001, tg(0, 5), '0);
      chk("t1_req", 64'(req), 64'h0001);
      chk("t1_np", 64'(np), 64'h1);

      cyc(16'h0008, tg(3, 9), '0);
      cyc('0, '0, 16'h0008);
      chk("t2_iv", 64'(iv), 64'h1);
      chk("t2_idx", 64'(idx), 64'h3);
      chk("t2_tag", 64'(itag), 64'h9);
      chk("t2_req", 64'(req), 64'h0001);

      cyc(16'h0004, tg(2, 4), '0);
      en = 16'h0004; ltag = tg(2, 6); gnt = '0;
      #1;
      chk("t3_stall", 64'(stall), 64'h0004);
      cyc(16'h0004, tg(2, 6), '0);
      en = 16'h0004; ltag = tg(2, 7); gnt = 16'h0004;
      #1;
      chk("t3_refill_stall", 64'(stall), 64'h0);
      cyc(16'h0004, tg(2, 7), 16'h0004);
      chk("t3_old_tag", 64'(itag), 64'h4);
      chk("t3_req2", 64'(req[2]), 64'h1);
      cyc('0, '0, 16'h0004);
      chk("t3_new_tag", 64'(itag), 64'h7);

      do_reset();
      cyc(16'h0001, tg(0, 1), '0);
      repeat (14) cyc('0, '0, '0);
      chk("t4_not_yet", 64'(starve), 64'h0);
      cyc('0, '0, '0);
      chk("t4_starve", 64'(starve), 64'h0001);
      cyc('0, '0, 16'h0001);
      chk("t4_clear", 64'(starve), 64'h0);

      cyc('0, '0, 16'h0100);
      chk("gnt_empty_iv", 64'(iv), 64'h0);
      chk("gnt_empty_req", 64'(req), 64'h0);
`ifdef PSEL_REQ_ISSUER_DEBUG_EN
      chk("dbg_err_empty", 64'(err_empty), 64'h1);
      chk("dbg_multi_clear", 64'(err_multi), 64'h0);
`endif

      cyc(16'h0030, tg(4, 3) | tg(5, 12), '0);
      cyc('0, '0, 16'h0030);
      chk("multi_idx", 64'(idx), 64'h4);
      chk("multi_tag", 64'(itag), 64'h3);
      chk("multi_req", 64'(req), 64'h0020);
`ifdef PSEL_REQ_ISSUER_DEBUG_EN
      chk("dbg_err_multi", 64'(err_multi), 64'h1);
`endif

      all_tags = '0;
      for (int i = 0; i < W; i++) all_tags[i*TW +: TW] = TW'(i + 20);
      cyc(16'hFFFF, all_tags, '0);
      chk("t5_np_full", 64'(np), 64'd16);
      en = 16'hFFFF; ltag = all_tags; gnt = '0;
      #1;
      chk("t5_stall_all", 64'(stall), 64'hFFFF);
      cyc(16'hFFFF, all_tags, '0);
      en = 16'hA5A5;
      do_reset();
      chk("t5_req_after", 64'(req), 64'h0);
`ifdef PSEL_REQ_ISSUER_DEBUG_EN
      chk("dbg_rst_clear", 64'({err_empty, err_multi}), 64'h0);
`endif
      cyc('0, '0, '0);
      cyc(16'h0202, tg(1, 2) | tg(9, 33), '0);
      cyc('0, '0, 16'h0200);
      chk("last_tag", 64'(itag), 64'd33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
